// File: rtl/pl_perf_pkg.sv
// Shared definitions for the PL_CPU performance-counter block.
//   perf_state_t : run / dump / done states of the statistics unit
//   IDX_*        : dump_index value that selects each counter on the dump stream
//   NUM_COUNTERS : number of statistics counters
//   IDX_W        : width of the dump index
package pl_perf_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      DUMP = 2'd1,
      DONE = 2'd2
   } perf_state_t;

   localparam int NUM_COUNTERS = 4;
   localparam int IDX_W        = 2;

   localparam logic [IDX_W-1:0] IDX_CYCLES = 2'd0;
   localparam logic [IDX_W-1:0] IDX_STALL  = 2'd1;
   localparam logic [IDX_W-1:0] IDX_BRANCH = 2'd2;
   localparam logic [IDX_W-1:0] IDX_MISS   = 2'd3;

endpackage

// File: rtl/perf_counter_unit_if.sv
// Valid/ready word stream that carries the frozen statistics out of the block.
//   dump_valid : word on dump_data is valid (master -> slave)
//   dump_ready : consumer accepts the word (slave -> master)
//   dump_data  : counter value (WIDTH bits)
//   dump_index : which counter is on dump_data (see IDX_* in pl_perf_pkg)
//   dump_last  : final word of the dump
interface perf_counter_unit_if
   import pl_perf_pkg::*;
   #(parameter int WIDTH = 32) ();

   logic             dump_valid;
   logic             dump_ready;
   logic [WIDTH-1:0] dump_data;
   logic [IDX_W-1:0] dump_index;
   logic             dump_last;

   modport master (
      output dump_valid,
      output dump_data,
      output dump_index,
      output dump_last,
      input  dump_ready
   );

   modport slave (
      input  dump_valid,
      input  dump_data,
      input  dump_index,
      input  dump_last,
      output dump_ready
   );

endinterface

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
//   input_clk : clock
//   rst       : asynchronous reset, clears count
//   en        : increment request for this edge
//   count     : current value; sticks at all-ones instead of wrapping
module perf_sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             input_clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge input_clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (en && (count != {WIDTH{1'b1}})) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/perf_counter_unit.sv
// Performance-counter unit for PL_CPU. Counts cycles, stall cycles, resolved
// branches and mispredictions while running; on hlt it freezes the counts and
// streams them out as four words (cycles, stall, branch, miss).
//   input_clk                 : pipeline clock
//   rst                       : asynchronous active-high reset
//   stall                     : pipeline bubble this cycle
//   branch_resolved           : a predicted branch resolved this cycle
//   branch_mispredict         : resolved branch was mispredicted
//   hlt                       : hlt reached commit this cycle
//   cycles_consumed           : cycle count
//   StallCount                : stall-cycle count
//   BranchPredictionCount     : resolved-branch count
//   BranchPredictionMissCount : misprediction count
//   halted                    : counters are frozen
//   dump_bus                  : valid/ready stream of the frozen counters
module perf_counter_unit
   import pl_perf_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             input_clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             branch_resolved,
   input  logic             branch_mispredict,
   input  logic             hlt,
   output logic [WIDTH-1:0] cycles_consumed,
   output logic [WIDTH-1:0] StallCount,
   output logic [WIDTH-1:0] BranchPredictionCount,
   output logic [WIDTH-1:0] BranchPredictionMissCount,
   output logic             halted,
   perf_counter_unit_if.master dump_bus
);

   perf_state_t state;
   logic counting;
   logic [NUM_COUNTERS-1:0] count_en;
   logic [WIDTH-1:0] counts [NUM_COUNTERS];

   // The hlt cycle itself is not counted; software adds it back.
   assign counting = (state == RUN) && !hlt;

   always_comb begin
      count_en = '0;
      count_en[IDX_CYCLES] = counting;
      count_en[IDX_STALL]  = counting && stall;
      count_en[IDX_BRANCH] = counting && branch_resolved;
      count_en[IDX_MISS]   = counting && branch_resolved && branch_mispredict;
   end

   for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_ctr
      perf_sat_counter #(.WIDTH(WIDTH)) u_ctr (
         .input_clk (input_clk),
         .rst       (rst),
         .en        (count_en[g]),
         .count     (counts[g])
      );
   end

   assign cycles_consumed           = counts[IDX_CYCLES];
   assign StallCount                = counts[IDX_STALL];
   assign BranchPredictionCount     = counts[IDX_BRANCH];
   assign BranchPredictionMissCount = counts[IDX_MISS];

   // Counters are frozen outside RUN, so the mux output is stable for the
   // whole time a word is offered.
   assign dump_bus.dump_data = counts[dump_bus.dump_index];

   // dump_last is precomputed when the index advances so it is a register
   // aligned with dump_index rather than a decode of it.
   always_ff @(posedge input_clk or posedge rst) begin
      if (rst) begin
         state               <= RUN;
         halted              <= 1'b0;
         dump_bus.dump_valid <= 1'b0;
         dump_bus.dump_index <= IDX_CYCLES;
         dump_bus.dump_last  <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (hlt) begin
                  state               <= DUMP;
                  halted              <= 1'b1;
                  dump_bus.dump_valid <= 1'b1;
                  dump_bus.dump_index <= IDX_CYCLES;
                  dump_bus.dump_last  <= 1'b0;
               end
            end
            DUMP: begin
               if (dump_bus.dump_valid && dump_bus.dump_ready) begin
                  if (dump_bus.dump_index == IDX_MISS) begin
                     state               <= DONE;
                     dump_bus.dump_valid <= 1'b0;
                     dump_bus.dump_last  <= 1'b0;
                  end else begin
                     dump_bus.dump_index <= dump_bus.dump_index + IDX_W'(1);
                     dump_bus.dump_last  <= (dump_bus.dump_index == IDX_BRANCH);
                  end
               end
            end
            DONE: begin
               state <= DONE;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_perf_counter_unit.sv
// Self-checking bench for perf_counter_unit. Two instances (WIDTH=32 and
// WIDTH=4) share all inputs; a reference model tallies raw events and
// saturates them per width. Expected dump words go into per-instance queues
// that negedge monitors pop and compare on every accepted word.
module tb_perf_counter_unit;
   import pl_perf_pkg::*;

   localparam int W  = 32;
   localparam int SW = 4;

   logic input_clk = 1'b0;
   logic rst = 1'b0;
   logic stall = 1'b0, branch_resolved = 1'b0, branch_mispredict = 1'b0, hlt = 1'b0;
   logic dump_ready = 1'b0;

   logic [W-1:0]  cyc, stc, brc, msc;
   logic [SW-1:0] cyc4, stc4, brc4, msc4;
   logic halted, halted4;

   perf_counter_unit_if #(.WIDTH(W))  bus ();
   perf_counter_unit_if #(.WIDTH(SW)) bus4 ();
   assign bus.dump_ready  = dump_ready;
   assign bus4.dump_ready = dump_ready;

   perf_counter_unit #(.WIDTH(W)) u_dut (
      .input_clk                 (input_clk),
      .rst                       (rst),
      .stall                     (stall),
      .branch_resolved           (branch_resolved),
      .branch_mispredict         (branch_mispredict),
      .hlt                       (hlt),
      .cycles_consumed           (cyc),
      .StallCount                (stc),
      .BranchPredictionCount     (brc),
      .BranchPredictionMissCount (msc),
      .halted                    (halted),
      .dump_bus                  (bus)
   );

   perf_counter_unit #(.WIDTH(SW)) u_sat (
      .input_clk                 (input_clk),
      .rst                       (rst),
      .stall                     (stall),
      .branch_resolved           (branch_resolved),
      .branch_mispredict         (branch_mispredict),
      .hlt                       (hlt),
      .cycles_consumed           (cyc4),
      .StallCount                (stc4),
      .BranchPredictionCount     (brc4),
      .BranchPredictionMissCount (msc4),
      .halted                    (halted4),
      .dump_bus                  (bus4)
   );

   always #5 input_clk = ~input_clk;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  idx;
      logic        last;
   } word_t;

   word_t q32[$], q4[$];
   word_t w32, w4, hold32, hold4;
   bit held32 = 1'b0, held4 = 1'b0;

   int nChecks = 0;
   int nFail = 0;

   // Reference model: raw event tallies plus run/halted flag.
   longint mCyc = 0, mStall = 0, mBr = 0, mMiss = 0;
   bit modelRun = 1'b1;

   function automatic logic [63:0] sat(input longint v, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   function automatic bit rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge input_clk);
      #1;
   endtask

   task automatic pushDump();
      longint vals[4];
      vals = '{mCyc, mStall, mBr, mMiss};
      for (int i = 0; i < 4; i++) begin
         q32.push_back('{data: 32'(sat(vals[i], W)),  idx: 2'(i), last: (i == 3)});
         q4.push_back ('{data: 32'(sat(vals[i], SW)), idx: 2'(i), last: (i == 3)});
      end
   endtask

   task automatic applyStimulus(input bit s, input bit b, input bit m, input bit h);
      bit justHalted;
      justHalted = 1'b0;
      stall = s;
      branch_resolved = b;
      branch_mispredict = m;
      hlt = h;
      if (modelRun) begin
         if (h) begin
            modelRun = 1'b0;
            justHalted = 1'b1;
         end else begin
            mCyc++;
            if (s) mStall++;
            if (b) mBr++;
            if (b && m) mMiss++;
         end
      end
      tick();
      if (justHalted) pushDump();
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, "_cycles"},  cyc,  sat(mCyc, W));
      checkOutput({tag, "_stall"},   stc,  sat(mStall, W));
      checkOutput({tag, "_branch"},  brc,  sat(mBr, W));
      checkOutput({tag, "_miss"},    msc,  sat(mMiss, W));
      checkOutput({tag, "_halted"},  halted, !modelRun);
      checkOutput({tag, "_cycles4"}, cyc4, sat(mCyc, SW));
      checkOutput({tag, "_stall4"},  stc4, sat(mStall, SW));
      checkOutput({tag, "_branch4"}, brc4, sat(mBr, SW));
      checkOutput({tag, "_miss4"},   msc4, sat(mMiss, SW));
      checkOutput({tag, "_halted4"}, halted4, !modelRun);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_cycles"}, cyc, 0);
      checkOutput({tag, "_stall"},  stc, 0);
      checkOutput({tag, "_branch"}, brc, 0);
      checkOutput({tag, "_miss"},   msc, 0);
      checkOutput({tag, "_halted"}, halted, 0);
      checkOutput({tag, "_valid"},  bus.dump_valid, 0);
      checkOutput({tag, "_index"},  bus.dump_index, 0);
      checkOutput({tag, "_data"},   bus.dump_data, 0);
      checkOutput({tag, "_last"},   bus.dump_last, 0);
      checkOutput({tag, "_cycles4"}, cyc4, 0);
      checkOutput({tag, "_halted4"}, halted4, 0);
      checkOutput({tag, "_valid4"},  bus4.dump_valid, 0);
      checkOutput({tag, "_index4"},  bus4.dump_index, 0);
   endtask

   task automatic doReset(input string tag);
      stall = 0; branch_resolved = 0; branch_mispredict = 0; hlt = 0; dump_ready = 0;
      rst = 1'b1;
      q32.delete();
      q4.delete();
      mCyc = 0; mStall = 0; mBr = 0; mMiss = 0;
      modelRun = 1'b1;
      #1;
      checkResetState(tag);
      @(posedge input_clk);
      #1;
      rst = 1'b0;
   endtask

   // pattern 0: ready always high, 1: ready 0,1,0,0,1 repeating, else random.
   task automatic drainDump(input string tag, input int pattern);
      int i;
      bit pat[5];
      i = 0;
      pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      while ((q32.size() != 0 || q4.size() != 0) && i < 40) begin
         case (pattern)
            0:       dump_ready = 1'b1;
            1:       dump_ready = pat[i % 5];
            default: dump_ready = rbit();
         endcase
         applyStimulus(rbit(), rbit(), rbit(), rbit());
         i++;
      end
      checkOutput({tag, "_drained"}, q32.size() + q4.size(), 0);
      if (pattern == 0) checkOutput({tag, "_dump_cycles"}, i, 4);
      checkOutput({tag, "_valid_done"},  bus.dump_valid, 0);
      checkOutput({tag, "_valid_done4"}, bus4.dump_valid, 0);
      dump_ready = 1'b0;
   endtask

   always @(negedge input_clk) begin
      if (rst) begin
         held32 = 1'b0;
      end else begin
         if (held32) begin
            checkOutput("hold_valid", bus.dump_valid, 1);
            checkOutput("hold_data",  bus.dump_data, hold32.data);
            checkOutput("hold_index", bus.dump_index, hold32.idx);
            checkOutput("hold_last",  bus.dump_last, hold32.last);
         end
         if (bus.dump_valid && bus.dump_ready) begin
            if (q32.size() == 0) begin
               nChecks++;
               nFail++;
               $display("[TB] FAIL unexpected_word: got index %0d data %0h, expected no word", bus.dump_index, bus.dump_data);
            end else begin
               w32 = q32.pop_front();
               checkOutput("word_data",  bus.dump_data, w32.data);
               checkOutput("word_index", bus.dump_index, w32.idx);
               checkOutput("word_last",  bus.dump_last, w32.last);
            end
         end
         held32 = bus.dump_valid && !bus.dump_ready;
         hold32 = '{data: bus.dump_data, idx: bus.dump_index, last: bus.dump_last};
      end
   end

   always @(negedge input_clk) begin
      if (rst) begin
         held4 = 1'b0;
      end else begin
         if (held4) begin
            checkOutput("hold_valid4", bus4.dump_valid, 1);
            checkOutput("hold_data4",  bus4.dump_data, hold4.data);
            checkOutput("hold_index4", bus4.dump_index, hold4.idx);
            checkOutput("hold_last4",  bus4.dump_last, hold4.last);
         end
         if (bus4.dump_valid && bus4.dump_ready) begin
            if (q4.size() == 0) begin
               nChecks++;
               nFail++;
               $display("[TB] FAIL unexpected_word4: got index %0d data %0h, expected no word", bus4.dump_index, bus4.dump_data);
            end else begin
               w4 = q4.pop_front();
               checkOutput("word_data4",  bus4.dump_data, w4.data);
               checkOutput("word_index4", bus4.dump_index, w4.idx);
               checkOutput("word_last4",  bus4.dump_last, w4.last);
            end
         end
         held4 = bus4.dump_valid && !bus4.dump_ready;
         hold4 = '{data: 32'(bus4.dump_data), idx: bus4.dump_index, last: bus4.dump_last};
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #2;
      doReset("reset0");

      // Idle run: only cycles advance, dump with ready held high.
      repeat (10) applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1);
      checkOutput("t1_cycles", cyc, 10);
      checkOutput("t1_stall", stc, 0);
      checkOutput("t1_valid", bus.dump_valid, 1);
      checkOutput("t1_index", bus.dump_index, 0);
      checkCounters("t1");
      drainDump("t1", 0);

      // Directed mix, hlt together with stall and branch, inputs poked in DUMP/DONE.
      doReset("reset1");
      for (int i = 0; i < 20; i++)
         applyStimulus(i < 5, (i >= 5) && (i < 11), (i == 5) || (i == 6) || (i == 15), 0);
      applyStimulus(1, 1, 1, 1);
      checkOutput("t2_cycles", cyc, 20);
      checkOutput("t2_stall",  stc, 5);
      checkOutput("t2_branch", brc, 6);
      checkOutput("t2_miss",   msc, 2);
      checkCounters("t2");
      drainDump("t2", 1);
      repeat (5) applyStimulus(1, rbit(), rbit(), 1);
      checkCounters("t2_done");
      checkOutput("t2_done_valid", bus.dump_valid, 0);

      // Saturation of the narrow instance.
      doReset("reset2");
      repeat (20) applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 1);
      checkOutput("t3_cycles4", cyc4, 15);
      checkOutput("t3_stall4",  stc4, 15);
      checkOutput("t3_cycles",  cyc, 20);
      checkCounters("t3");
      drainDump("t3", 2);

      // Randomized runs.
      for (int t = 0; t < 4; t++) begin
         doReset("reset_rand");
         repeat ($urandom_range(3, 40)) applyStimulus(rbit(), rbit(), rbit(), 0);
         applyStimulus(rbit(), rbit(), rbit(), 1);
         checkCounters("rand");
         drainDump("rand", 2);
      end

      // Reset after word 1 is accepted, then a clean new run.
      doReset("reset3");
      repeat (9) applyStimulus(rbit(), rbit(), rbit(), 0);
      applyStimulus(0, 0, 0, 1);
      dump_ready = 1'b1;
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      dump_ready = 1'b0;
      checkOutput("t4_index_before_rst", bus.dump_index, 2);
      doReset("reset_mid");
      repeat (7) applyStimulus(rbit(), rbit(), rbit(), 0);
      applyStimulus(0, 0, 0, 1);
      checkOutput("t4_cycles", cyc, 7);
      checkCounters("t4");
      drainDump("t4", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/perf_counter_unit.md
# perf_counter_unit

Performance-counter block inside PL_CPU, the producer side of the statistics the simulation bench prints. It counts consumed cycles, stall cycles, resolved branch predictions and mispredictions. On `hlt` it freezes all counts. It then streams the four frozen values out over a valid/ready word interface, so a bench or debug port can read final statistics without probing internal nets.

## Interface
- `WIDTH`, 32, width of each counter and of `dump_data`
- `input_clk`  in  1  pipeline clock
- `rst`  in  1  reset, asynchronous, active-high
- `stall`  in  1  pipeline inserted a bubble this cycle
- `branch_resolved`  in  1  a predicted branch resolved this cycle
- `branch_mispredict`  in  1  resolved branch was mispredicted; only meaningful with `branch_resolved`
- `hlt`  in  1  hlt instruction reached commit this cycle
- `cycles_consumed`  out  WIDTH  cycle count
- `StallCount`  out  WIDTH  stall-cycle count
- `BranchPredictionCount`  out  WIDTH  resolved-branch count
- `BranchPredictionMissCount`  out  WIDTH  misprediction count
- `halted`  out  1  counters frozen
- `dump_valid`  out  1  `dump_data` holds a valid word
- `dump_ready`  in  1  consumer accepts the word
- `dump_data`  out  WIDTH  streamed counter value
- `dump_index`  out  2  which counter is on `dump_data`: 0 cycles, 1 stall, 2 branch, 3 miss
- `dump_last`  out  1  high with index 3

## Operation
- FSM states are RUN, DUMP and DONE. Reset enters RUN.
- RUN counting, per rising edge with `hlt`=0:
  - `cycles_consumed` += 1
  - `stall` → `StallCount` += 1
  - `branch_resolved` → `BranchPredictionCount` += 1
  - `branch_resolved` & `branch_mispredict` → `BranchPredictionMissCount` += 1
  - `branch_mispredict` without `branch_resolved` is ignored.
- Saturation:
  - Every counter saturates at 2^WIDTH−1 and never wraps.
  - Each counter saturates independently.
- Halt:
  - RUN with `hlt`=1 → DUMP.
  - Nothing is counted in the hlt cycle, including `stall` and branch inputs that are high in that cycle. Software adds 1 to get total cycles.
- DUMP:
  - `dump_valid`=1 and `dump_index` starts at 0.
  - On `dump_valid`&`dump_ready`: if `dump_index`=3, go to DONE; otherwise increment `dump_index`.
- DONE:
  - `dump_valid`=0 and the counters stay frozen.
  - Only `rst` leaves DONE.
- In DUMP and DONE, all event inputs including `hlt` are ignored.
- `halted` = (state != RUN).
- `dump_data` is a mux of the frozen counter selected by `dump_index`.

## Timing
- Reset values: all counters 0, `halted`=0, `dump_valid`=0, `dump_index`=0, `dump_data`=0, `dump_last`=0, state RUN.
- `rst` asserted in any state, including mid-dump, returns everything to reset values asynchronously.
- Counting begins at the first rising edge after `rst` deasserts.
- Counter outputs are registered. An event sampled at edge N is visible after edge N.
- `halted` and `dump_valid` rise after the edge that samples `hlt`. Word 0 is offered that same cycle.
- Handshake:
  - `dump_data`, `dump_index` and `dump_last` are held stable while `dump_valid`&!`dump_ready`.
  - `dump_valid` never drops before acceptance.
- Throughput:
  - With `dump_ready` held high, words 0–3 transfer on 4 consecutive edges.
  - `dump_valid` falls after the 4th edge.
- `dump_ready` is don't-care when `dump_valid`=0.

## Structure
- Package `pl_perf_pkg`:
  - state enum: RUN, DUMP, DONE
  - index constants: IDX_CYCLES=0, IDX_STALL=1, IDX_BRANCH=2, IDX_MISS=3
  - NUM_COUNTERS=4
- Sub-module `perf_sat_counter`:
  - parameter WIDTH; inputs `input_clk`, `rst`, `en`; output `count`
  - saturating increment with async reset
  - instantiated four times

## Test plan
- Reset, run 10 cycles with no events, then pulse `hlt` → `cycles_consumed`=10 and all other counters 0. Dump with ready high gives 10, 0, 0, 0 on indices 0–3 in 4 cycles; `dump_last` is high only on index 3.
- In 20 run cycles, assert `stall` on 5, `branch_resolved` on 6, and `branch_resolved`&`branch_mispredict` on 2 of those 6. Assert `branch_mispredict` alone once. Then `hlt` → counts 20, 5, 6, 2.
- Assert `hlt` together with `stall` and `branch_resolved` → neither counts. Further `hlt` and `stall` pulses in DUMP and DONE change nothing.
- Dump with `dump_ready` toggling 0,1,0,0,1,… → each word is held stable until accepted. The sequence arrives exactly once, in order, with no skipped index.
- WIDTH=4, 20 run cycles with `stall` always high → `cycles_consumed`=15 and `StallCount`=15, saturated with no wrap.
- Assert `rst` after word 1 is accepted → all outputs are 0 and the state is RUN. A new count and dump starts cleanly from 0.
